iq_discriminator: RTL and testbench



---
 rtl/iq_demod_pkg.sv | 15 +
 rtl/iq_pair_align.sv | 102 ++++++++++
 rtl/iq_discriminator.sv | 113 +++++++++++
 tb/tb_iq_discriminator.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iq_demod_pkg.sv
// Shared types for the IQ demodulator back end: sample/discriminator widths and pairing states.
package iq_demod_pkg;

    localparam int DW     = 5;
    localparam int DISC_W = 2*DW+1;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        HAVE_I = 2'd1,
        HAVE_Q = 2'd2
    } pair_state_t;

    typedef logic signed [DISC_W-1:0] disc_t;

endpackage

// File: rtl/iq_pair_align.sv
// Pairs independently-validated I and Q samples; the pair fires combinationally in the cycle the later half arrives.
// No backpressure: a second sample of the same rail before its partner overwrites the stored one and flags align_err.
module iq_pair_align #(
    parameter int DW = 5
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          i_sync_clr,
    input  logic [DW-1:0] i_i_dat,
    input  logic          i_i_vld,
    input  logic [DW-1:0] i_q_dat,
    input  logic          i_q_vld,
    output logic          o_pair_vld,
    output logic [DW-1:0] o_pair_i,
    output logic [DW-1:0] o_pair_q,
    output logic          o_first,
    output logic          o_align_err
);
    import iq_demod_pkg::*;

    pair_state_t   r_state;
    pair_state_t   w_next;
    logic [DW-1:0] r_i;
    logic [DW-1:0] r_q;
    logic          r_first;
    logic          r_align_err;
    logic          w_store_i;
    logic          w_store_q;
    logic          w_err;

    always_comb begin
        w_next     = r_state;
        o_pair_vld = 1'b0;
        o_pair_i   = i_i_dat;
        o_pair_q   = i_q_dat;
        w_store_i  = 1'b0;
        w_store_q  = 1'b0;
        w_err      = 1'b0;
        case (r_state)
            EMPTY: begin
                if (i_i_vld && i_q_vld) begin
                    o_pair_vld = 1'b1;
                end else if (i_i_vld) begin
                    w_store_i = 1'b1;
                    w_next    = HAVE_I;
                end else if (i_q_vld) begin
                    w_store_q = 1'b1;
                    w_next    = HAVE_Q;
                end
            end
            HAVE_I: begin
                o_pair_i = r_i;
                if (i_q_vld) begin
                    o_pair_vld = 1'b1;
                    w_store_i  = i_i_vld;
                    w_next     = i_i_vld ? HAVE_I : EMPTY;
                end else if (i_i_vld) begin
                    w_store_i = 1'b1;
                    w_err     = 1'b1;
                end
            end
            HAVE_Q: begin
                o_pair_q = r_q;
                if (i_i_vld) begin
                    o_pair_vld = 1'b1;
                    w_store_q  = i_q_vld;
                    w_next     = i_q_vld ? HAVE_Q : EMPTY;
                end else if (i_q_vld) begin
                    w_store_q = 1'b1;
                    w_err     = 1'b1;
                end
            end
            default: w_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= EMPTY;
            r_i         <= '0;
            r_q         <= '0;
            r_first     <= 1'b1;
            r_align_err <= 1'b0;
        end else if (i_sync_clr) begin
            r_state     <= EMPTY;
            r_i         <= '0;
            r_q         <= '0;
            r_first     <= 1'b1;
            r_align_err <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_align_err <= w_err;
            if (w_store_i)  r_i     <= i_i_dat;
            if (w_store_q)  r_q     <= i_q_dat;
            if (o_pair_vld) r_first <= 1'b0;
        end
    end

    assign o_first     = r_first;
    assign o_align_err = r_align_err;

endmodule

// File: rtl/iq_discriminator.sv
// Differential phase discriminator I[n-1]*Q[n] - Q[n-1]*I[n] with chip decimation; disc 2 edges after pairing, chip 1 later.
// Sustains one pair per cycle; no backpressure, sync_clr drops everything in flight.
module iq_discriminator #(
    parameter int DW    = 5,
    parameter int DECIM = 4,
    parameter int PW    = 2
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic [DW-1:0] i_in,
    input  logic          i_valid,
    input  logic [DW-1:0] q_in,
    input  logic          q_valid,
    input  logic          sync_clr,
    input  logic [PW-1:0] decim_phase,
    output logic [2*DW:0] disc_out,
    output logic          disc_valid,
    output logic          chip_out,
    output logic [2*DW:0] chip_soft,
    output logic          chip_valid,
    output logic          align_err
);
    import iq_demod_pkg::*;

    localparam int MW = 2*DW;
    localparam int LW = 2*DW+1;

    logic                 w_fire;
    logic [DW-1:0]        w_pair_i;
    logic [DW-1:0]        w_pair_q;
    logic                 w_first;
    logic signed [DW-1:0] r_prev_i, r_prev_q, r_cur_i, r_cur_q;
    logic                 r_v0, r_v1;
    logic signed [MW-1:0] r_p1, r_p2;
    logic signed [MW-1:0] w_p1, w_p2;
    logic signed [LW-1:0] w_diff;
    logic [PW-1:0]        r_cnt;
    logic                 w_pos, w_neg;

    iq_pair_align #(.DW(DW)) u_pair (
        .clk         (clk),
        .resetn      (resetn),
        .i_sync_clr  (sync_clr),
        .i_i_dat     (i_in),
        .i_i_vld     (i_valid),
        .i_q_dat     (q_in),
        .i_q_vld     (q_valid),
        .o_pair_vld  (w_fire),
        .o_pair_i    (w_pair_i),
        .o_pair_q    (w_pair_q),
        .o_first     (w_first),
        .o_align_err (align_err)
    );

    assign w_p1   = MW'(r_prev_i) * MW'(r_cur_q);
    assign w_p2   = MW'(r_prev_q) * MW'(r_cur_i);
    assign w_diff = LW'(r_p1) - LW'(r_p2);
    assign w_pos  = ~disc_out[2*DW] & (|disc_out);
    assign w_neg  = disc_out[2*DW];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_prev_i   <= '0;
            r_prev_q   <= '0;
            r_cur_i    <= '0;
            r_cur_q    <= '0;
            r_v0       <= 1'b0;
            r_v1       <= 1'b0;
            r_p1       <= '0;
            r_p2       <= '0;
            r_cnt      <= '0;
            disc_out   <= '0;
            disc_valid <= 1'b0;
            chip_out   <= 1'b0;
            chip_soft  <= '0;
            chip_valid <= 1'b0;
        end else if (sync_clr) begin
            // Clearing every valid stage blanks disc/chip pulses for the next three cycles; data outputs hold.
            r_prev_i   <= '0;
            r_prev_q   <= '0;
            r_cur_i    <= '0;
            r_cur_q    <= '0;
            r_v0       <= 1'b0;
            r_v1       <= 1'b0;
            r_cnt      <= '0;
            disc_valid <= 1'b0;
            chip_valid <= 1'b0;
        end else begin
            r_v0 <= w_fire & ~w_first;
            if (w_fire) begin
                r_prev_i <= r_cur_i;
                r_prev_q <= r_cur_q;
                r_cur_i  <= w_pair_i;
                r_cur_q  <= w_pair_q;
            end
            r_v1 <= r_v0;
            r_p1 <= w_p1;
            r_p2 <= w_p2;
            disc_valid <= r_v1;
            if (r_v1) disc_out <= w_diff;
            chip_valid <= disc_valid && (r_cnt == decim_phase);
            if (disc_valid) begin
                r_cnt <= (r_cnt == PW'(DECIM-1)) ? '0 : r_cnt + 1'b1;
                if (r_cnt == decim_phase) begin
                    chip_soft <= disc_out;
                    if (w_pos)      chip_out <= 1'b1;
                    else if (w_neg) chip_out <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_iq_discriminator.sv
// Directed and randomized bench for iq_discriminator with an event-level reference model.
module tb_iq_discriminator;
    import iq_demod_pkg::*;

    localparam int DECIM = 4;

    typedef struct {
        int tag;
        int val;
        int bit_v;
    } ev_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic [4:0]  i_in, q_in;
    logic        i_valid, q_valid, sync_clr;
    logic [1:0]  decim_phase;
    disc_t       disc_out, chip_soft;
    logic        disc_valid, chip_out, chip_valid, align_err;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    ev_t exp_d[$], obs_d[$], exp_c[$], obs_c[$], m_sched[$];
    int  exp_e[$], obs_e[$];

    int m_has_i, m_has_q, m_pi, m_pq, m_first, m_cur_i, m_cur_q;
    int m_cnt, m_last, m_md_vld, m_md_val;

    iq_discriminator #(.DW(5), .DECIM(4), .PW(2)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .i_in        (i_in),
        .i_valid     (i_valid),
        .q_in        (q_in),
        .q_valid     (q_valid),
        .sync_clr    (sync_clr),
        .decim_phase (decim_phase),
        .disc_out    (disc_out),
        .disc_valid  (disc_valid),
        .chip_out    (chip_out),
        .chip_soft   (chip_soft),
        .chip_valid  (chip_valid),
        .align_err   (align_err)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_has_i = 0; m_has_q = 0; m_pi = 0; m_pq = 0; m_first = 1;
        m_cur_i = 0; m_cur_q = 0; m_cnt = 0; m_last = 0; m_md_vld = 0; m_md_val = 0;
        m_sched.delete();
    endtask

    task automatic log_clear();
        exp_d.delete(); obs_d.delete(); exp_c.delete(); obs_c.delete();
        exp_e.delete(); obs_e.delete();
    endtask

    // Reference behaviour at one clock edge, in terms of pairs, discriminator events and chip instants.
    task automatic model_edge(input bit iv, input int id, input bit qv, input int qd, input bit sc);
        bit  fire;
        int  fi, fq;
        ev_t ev;
        fire = 0; fi = 0; fq = 0;
        if (sc) begin
            m_cnt = 0;
            m_sched.delete();
        end else if (m_md_vld != 0) begin
            if (m_cnt == int'(decim_phase)) begin
                if (m_md_val > 0) m_last = 1;
                else if (m_md_val < 0) m_last = 0;
                ev.tag = cyc; ev.val = m_md_val; ev.bit_v = m_last;
                exp_c.push_back(ev);
            end
            m_cnt = (m_cnt + 1) % DECIM;
        end
        m_md_vld = 0;
        if (!sc && m_sched.size() > 0 && m_sched[0].tag == cyc) begin
            ev = m_sched.pop_front();
            exp_d.push_back(ev);
            m_md_vld = 1;
            m_md_val = ev.val;
        end
        if (sc) begin
            m_has_i = 0; m_has_q = 0; m_first = 1; m_cur_i = 0; m_cur_q = 0;
        end else begin
            if (m_has_i != 0) begin
                if (qv) begin
                    fire = 1; fi = m_pi; fq = qd; m_has_i = int'(iv);
                    if (iv) m_pi = id;
                end else if (iv) begin
                    m_pi = id; exp_e.push_back(cyc);
                end
            end else if (m_has_q != 0) begin
                if (iv) begin
                    fire = 1; fi = id; fq = m_pq; m_has_q = int'(qv);
                    if (qv) m_pq = qd;
                end else if (qv) begin
                    m_pq = qd; exp_e.push_back(cyc);
                end
            end else begin
                if (iv && qv) begin fire = 1; fi = id; fq = qd; end
                else if (iv) begin m_has_i = 1; m_pi = id; end
                else if (qv) begin m_has_q = 1; m_pq = qd; end
            end
            if (fire) begin
                if (m_first != 0) begin
                    m_first = 0;
                end else begin
                    ev.tag = cyc + 2; ev.val = m_cur_i * fq - m_cur_q * fi; ev.bit_v = 0;
                    m_sched.push_back(ev);
                end
                m_cur_i = fi; m_cur_q = fq;
            end
        end
    endtask

    // One clock: drive after a falling edge, model the rising edge, record outputs at the next falling edge.
    task automatic step(input bit iv, input int id, input bit qv, input int qd, input bit sc);
        ev_t ev;
        i_valid = iv; i_in = id[4:0]; q_valid = qv; q_in = qd[4:0]; sync_clr = sc;
        @(posedge clk);
        cyc++;
        model_edge(iv, id, qv, qd, sc);
        @(negedge clk);
        if (disc_valid) begin
            ev.tag = cyc; ev.val = int'(disc_out); ev.bit_v = 0;
            obs_d.push_back(ev);
        end
        if (chip_valid) begin
            ev.tag = cyc; ev.val = int'(chip_soft); ev.bit_v = int'(chip_out);
            obs_c.push_back(ev);
        end
        if (align_err) obs_e.push_back(cyc);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        n_checks++;
        if ({disc_out, chip_soft, disc_valid, chip_out, chip_valid, align_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: disc=%0d soft=%0d dv=%b co=%b cv=%b ae=%b, required all 0",
                     disc_out, chip_soft, disc_valid, chip_out, chip_valid, align_err);
        end
        resetn = 1'b1;
        idle(2);
        n_checks++;
        if ({disc_valid, chip_valid, align_err} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_idle: dv=%b cv=%b ae=%b, required 000", disc_valid, chip_valid, align_err);
        end
    endtask

    task automatic test_ccw();
        int pi[5] = '{4, 0, -4, 0, 4};
        int pq[5] = '{0, 4, 0, -4, 0};
        step(0, 0, 0, 0, 1);
        decim_phase = 2'd3;
        log_clear();
        for (int k = 0; k < 5; k++) step(1, pi[k], 1, pq[k], 0);
        idle(5);
        n_checks++;
        if (obs_d.size() != 4) begin
            n_fail++; $display("FAIL ccw_count: got %0d disc pulses, required 4", obs_d.size());
        end
        for (int k = 0; k < obs_d.size(); k++) begin
            n_checks++;
            if (obs_d[k].val != 16 || obs_d[k].tag != obs_d[0].tag + k) begin
                n_fail++;
                $display("FAIL ccw_disc%0d: got %0d at +%0d, required 16 at +%0d", k, obs_d[k].val, obs_d[k].tag - obs_d[0].tag, k);
            end
        end
        n_checks++;
        if (obs_c.size() != 1 || obs_d.size() != 4) begin
            n_fail++; $display("FAIL ccw_chip_count: got %0d chips, required 1", obs_c.size());
        end else if (obs_c[0].bit_v != 1 || obs_c[0].val != 16 || obs_c[0].tag != obs_d[3].tag + 1) begin
            n_fail++;
            $display("FAIL ccw_chip: got chip=%0d soft=%0d at %0d, required 1/16 at %0d",
                     obs_c[0].bit_v, obs_c[0].val, obs_c[0].tag, obs_d[3].tag + 1);
        end
    endtask

    task automatic test_cw();
        int pi[3] = '{4, 0, -4};
        int pq[3] = '{0, -4, 0};
        step(0, 0, 0, 0, 1);
        decim_phase = 2'd1;
        log_clear();
        for (int k = 0; k < 3; k++) step(1, pi[k], 1, pq[k], 0);
        idle(5);
        n_checks++;
        if (obs_d.size() != 2) begin
            n_fail++; $display("FAIL cw_count: got %0d disc pulses, required 2", obs_d.size());
        end else if (obs_d[0].val != -16 || obs_d[1].val != -16) begin
            n_fail++; $display("FAIL cw_disc: got %0d,%0d, required -16,-16", obs_d[0].val, obs_d[1].val);
        end
        n_checks++;
        if (obs_c.size() != 1) begin
            n_fail++; $display("FAIL cw_chip_count: got %0d chips, required 1", obs_c.size());
        end else if (obs_c[0].bit_v != 0 || obs_c[0].val != -16) begin
            n_fail++; $display("FAIL cw_chip: got chip=%0d soft=%0d, required 0/-16", obs_c[0].bit_v, obs_c[0].val);
        end
    endtask

    task automatic test_staggered();
        int t1, t2;
        step(0, 0, 0, 0, 1);
        log_clear();
        step(1, 1, 1, 1, 0);
        step(1, 7, 0, 0, 0);
        idle(2);
        step(0, 0, 1, -2, 0);
        t1 = cyc;
        idle(4);
        step(0, 0, 1, 3, 0);
        idle(2);
        step(1, -5, 0, 0, 0);
        t2 = cyc;
        idle(4);
        n_checks++;
        if (obs_d.size() != 2) begin
            n_fail++; $display("FAIL stagger_count: got %0d disc pulses, required 2", obs_d.size());
        end else begin
            n_checks++;
            if (obs_d[0].tag != t1 + 2 || obs_d[0].val != -9) begin
                n_fail++; $display("FAIL stagger_iq: got %0d at %0d, required -9 at %0d", obs_d[0].val, obs_d[0].tag, t1 + 2);
            end
            n_checks++;
            if (obs_d[1].tag != t2 + 2 || obs_d[1].val != 11) begin
                n_fail++; $display("FAIL stagger_qi: got %0d at %0d, required 11 at %0d", obs_d[1].val, obs_d[1].tag, t2 + 2);
            end
        end
        n_checks++;
        if (obs_e.size() != 0) begin
            n_fail++; $display("FAIL stagger_align_err: got %0d pulses, required 0", obs_e.size());
        end
    endtask

    task automatic test_overrun();
        int te;
        step(0, 0, 0, 0, 1);
        log_clear();
        step(1, 2, 1, 2, 0);
        step(1, 3, 0, 0, 0);
        step(1, 5, 0, 0, 0);
        te = cyc;
        step(0, 0, 1, 1, 0);
        idle(4);
        n_checks++;
        if (obs_e.size() != 1) begin
            n_fail++; $display("FAIL overrun_err_count: got %0d pulses, required 1", obs_e.size());
        end else if (obs_e[0] != te) begin
            n_fail++; $display("FAIL overrun_err_time: got cycle %0d, required %0d", obs_e[0], te);
        end
        n_checks++;
        if (obs_d.size() != 1) begin
            n_fail++; $display("FAIL overrun_disc_count: got %0d, required 1", obs_d.size());
        end else if (obs_d[0].val != -8) begin
            n_fail++; $display("FAIL overrun_disc: got %0d, required -8", obs_d[0].val);
        end
    endtask

    task automatic test_extremes();
        step(0, 0, 0, 0, 1);
        log_clear();
        step(1, -16, 1, 15, 0);
        step(1, 15, 1, -16, 0);
        idle(4);
        step(0, 0, 0, 0, 1);
        step(1, -16, 1, -16, 0);
        step(1, 15, 1, -16, 0);
        idle(4);
        n_checks++;
        if (obs_d.size() != 2) begin
            n_fail++; $display("FAIL extreme_count: got %0d, required 2", obs_d.size());
        end else begin
            n_checks++;
            if (obs_d[0].val != 31) begin
                n_fail++; $display("FAIL extreme_31: got %0d, required 31", obs_d[0].val);
            end
            n_checks++;
            if (obs_d[1].val != 496) begin
                n_fail++; $display("FAIL extreme_496: got %0d, required 496", obs_d[1].val);
            end
        end
    endtask

    task automatic test_zero_and_sync();
        int s, n_after, first_tag;
        step(0, 0, 0, 0, 1);
        decim_phase = 2'd0;
        log_clear();
        step(1, 1, 1, 0, 0);
        for (int k = 1; k <= 5; k++) step(1, 0, 1, k, 0);
        idle(4);
        n_checks++;
        if (obs_c.size() != 2) begin
            n_fail++; $display("FAIL zero_chip_count: got %0d, required 2", obs_c.size());
        end else if (obs_c[1].bit_v != 1 || obs_c[1].val != 0) begin
            n_fail++; $display("FAIL zero_repeat: got chip=%0d soft=%0d, required 1/0", obs_c[1].bit_v, obs_c[1].val);
        end
        log_clear();
        s = 0;
        for (int k = 0; k < 8; k++) begin
            step(1, k - 3, 1, 2 * k - 7, k == 3);
            if (k == 3) s = cyc;
        end
        idle(5);
        n_after = 0;
        first_tag = -1;
        foreach (obs_d[k]) begin
            if (obs_d[k].tag > s) n_after++;
            if (obs_d[k].tag > s && first_tag < 0) first_tag = obs_d[k].tag;
        end
        n_checks++;
        if (n_after != 3 || first_tag != s + 4) begin
            n_fail++; $display("FAIL sync_disc: got %0d pulses first at %0d, required 3 first at %0d", n_after, first_tag, s + 4);
        end
        foreach (obs_c[k]) begin
            n_checks++;
            if (obs_c[k].tag >= s && obs_c[k].tag <= s + 2) begin
                n_fail++; $display("FAIL sync_chip_blank: chip pulse at %0d inside blank window %0d..%0d", obs_c[k].tag, s, s + 2);
            end
        end
        n_checks++;
        if (obs_c.size() == 0 || obs_c[obs_c.size()-1].tag != s + 5) begin
            n_fail++; $display("FAIL sync_counter_restart: got %0d chips, required last at %0d", obs_c.size(), s + 5);
        end
    endtask

    task automatic test_random();
        log_clear();
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(31, 0) == 0) decim_phase = 2'($urandom_range(3, 0));
            step(bit'($urandom_range(2, 0) != 0), int'($urandom_range(31, 0)) - 16,
                 bit'($urandom_range(2, 0) != 0), int'($urandom_range(31, 0)) - 16,
                 bit'($urandom_range(63, 0) == 0));
        end
        idle(5);
        n_checks++;
        if (obs_d.size() != exp_d.size() || obs_c.size() != exp_c.size() || obs_e.size() != exp_e.size()) begin
            n_fail++;
            $display("FAIL random_counts: disc %0d/%0d chip %0d/%0d err %0d/%0d (got/required)",
                     obs_d.size(), exp_d.size(), obs_c.size(), exp_c.size(), obs_e.size(), exp_e.size());
        end
        for (int k = 0; k < obs_d.size() && k < exp_d.size(); k++) begin
            n_checks++;
            if (obs_d[k].tag != exp_d[k].tag || obs_d[k].val != exp_d[k].val) begin
                n_fail++;
                $display("FAIL random_disc%0d: got %0d at %0d, required %0d at %0d", k, obs_d[k].val, obs_d[k].tag, exp_d[k].val, exp_d[k].tag);
            end
        end
        for (int k = 0; k < obs_c.size() && k < exp_c.size(); k++) begin
            n_checks++;
            if (obs_c[k].tag != exp_c[k].tag || obs_c[k].val != exp_c[k].val || obs_c[k].bit_v != exp_c[k].bit_v) begin
                n_fail++;
                $display("FAIL random_chip%0d: got %0d/%0d at %0d, required %0d/%0d at %0d", k, obs_c[k].bit_v, obs_c[k].val,
                         obs_c[k].tag, exp_c[k].bit_v, exp_c[k].val, exp_c[k].tag);
            end
        end
        for (int k = 0; k < obs_e.size() && k < exp_e.size(); k++) begin
            n_checks++;
            if (obs_e[k] != exp_e[k]) begin
                n_fail++; $display("FAIL random_err%0d: got cycle %0d, required %0d", k, obs_e[k], exp_e[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        log_clear();
        for (int k = 0; k < 6; k++) step(1, k * 3 - 8, 1, 7 - k * 2, 0);
        i_valid = 1'b0; q_valid = 1'b0; sync_clr = 1'b0;
        resetn = 1'b0;
        #1;
        n_checks++;
        if ({disc_out, chip_soft, disc_valid, chip_out, chip_valid, align_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: disc=%0d soft=%0d dv=%b co=%b cv=%b ae=%b, required all 0",
                     disc_out, chip_soft, disc_valid, chip_out, chip_valid, align_err);
        end
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        model_reset();
        log_clear();
        step(1, 5, 1, -3, 0);
        step(1, -2, 1, 6, 0);
        step(1, 4, 1, 4, 0);
        idle(4);
        n_checks++;
        if (obs_d.size() != 2 || exp_d.size() != 2) begin
            n_fail++; $display("FAIL reset_mid_count: got %0d disc pulses, required 2", obs_d.size());
        end else if (obs_d[0].val != exp_d[0].val || obs_d[1].val != exp_d[1].val) begin
            n_fail++;
            $display("FAIL reset_mid_disc: got %0d,%0d, required %0d,%0d", obs_d[0].val, obs_d[1].val, exp_d[0].val, exp_d[1].val);
        end
    endtask

    initial begin
        resetn = 1'b0;
        i_in = '0; q_in = '0; i_valid = 1'b0; q_valid = 1'b0; sync_clr = 1'b0; decim_phase = '0;
        model_reset();
        repeat (2) @(negedge clk);
        test_reset();
        test_ccw();
        test_cw();
        test_staggered();
        test_overrun();
        test_extremes();
        test_zero_and_sync();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
